// File: rtl/mem_io_bridge.sv
// Memory/IO bridge: turns a CPU req/ready access into timed SRAM strobes, or
// into a switch read / hex-display write when the single IO address is hit.
module mem_io_bridge #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int SW_W        = 10,
  parameter int HEX_DIGITS  = 4,
  parameter int WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(16'hFFFF)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Req,
  input  logic                    Wr,
  input  logic [ADDR_W-1:0]       Addr,
  input  logic [DATA_W-1:0]       Wdata,
  output logic [DATA_W-1:0]       Rdata,
  output logic                    Ready,
  output logic                    Busy,
  input  logic [SW_W-1:0]         SW,
  output logic [7*HEX_DIGITS-1:0] HEX,
  output logic [ADDR_W-1:0]       Mem_addr,
  output logic [DATA_W-1:0]       Mem_wdata,
  input  logic [DATA_W-1:0]       Mem_rdata,
  output logic                    Mem_OE_N,
  output logic                    Mem_WE_N
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int HEX_W = 4 * HEX_DIGITS;

  typedef enum logic [1:0] {IDLE, IO, ACCESS, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               wr_reg, wr_next;
  logic [HEX_W-1:0]   io_data_reg;
  logic [HEX_W-1:0]   hex_reg;
  logic               accept_io, accept_mem;
  logic               oe_n_next, we_n_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wr_next    = wr_reg;
    accept_io  = 1'b0;
    accept_mem = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Req) begin
          wr_next = Wr;
          if (Addr == IO_ADDR) begin
            accept_io  = 1'b1;
            state_next = IO;
          end else begin
            accept_mem = 1'b1;
            state_next = ACCESS;
            cnt_next   = CNT_W'(WAIT_STATES);
          end
        end
      end
      IO:     state_next = DONE;
      ACCESS: begin
        if (cnt_reg == '0) state_next = DONE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Strobes are registered from the upcoming state so they track ACCESS exactly.
    oe_n_next = !((state_next == ACCESS) && !wr_next);
    we_n_next = !((state_next == ACCESS) &&  wr_next);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      wr_reg      <= 1'b0;
      io_data_reg <= '0;
      hex_reg     <= '0;
      Rdata       <= '0;
      Ready       <= 1'b0;
      Busy        <= 1'b0;
      Mem_addr    <= '0;
      Mem_wdata   <= '0;
      Mem_OE_N    <= 1'b1;
      Mem_WE_N    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wr_reg    <= wr_next;
      Ready     <= (state_next == DONE);
      Busy      <= (state_next != IDLE);
      Mem_OE_N  <= oe_n_next;
      Mem_WE_N  <= we_n_next;
      if (accept_mem) begin
        Mem_addr  <= Addr;
        Mem_wdata <= Wdata;
      end
      if (accept_io)
        io_data_reg <= Wdata[HEX_W-1:0];
      if (state_reg == IO) begin
        if (wr_reg) hex_reg <= io_data_reg;
        else        Rdata   <= DATA_W'(SW);
      end
      // Read data is captured on the last strobed cycle, while OE is still low.
      if ((state_reg == ACCESS) && (cnt_reg == '0) && !wr_reg)
        Rdata <= Mem_rdata;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < HEX_DIGITS; gi++) begin : g_digit
      assign HEX[7*gi +: 7] = seg7(hex_reg[4*gi +: 4]);
    end
  endgenerate

endmodule
